// File: rtl/uart_tx_controller.sv
// uart_tx_controller
// Transmit-side sequencer for the UART Tx unit. A byte is accepted through a
// start/busy/done handshake and serialised as: start bit, data bits (LSB
// first), optional parity bit, then one or two stop bits. One baud_clk cycle
// is one bit time. Every output is registered: each output's next value is
// computed together with the next state, so the line changes exactly on the
// edge where the state changes.
//
// Handshake (tx_start / busy / done):
//   tx_start is sampled only on an edge where the current state is IDLE
//   (busy=0). When it is sampled high, data_in and the frame configuration
//   are captured on that edge, and busy=1 with tx=0 appear from the next
//   cycle. While busy=1, tx_start is ignored: it is not queued and raises no
//   error. When the last stop bit ends, busy falls and done pulses high for
//   exactly one cycle. That done cycle is an IDLE cycle, so a tx_start held
//   high during it is accepted and the next frame's start bit follows
//   directly.

module uart_tx_controller #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  baud_clk,
    input  logic                  rst,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  parity_en,
    input  logic                  parity_sel,
    input  logic                  two_stop,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            dbg_state_o
);

    // bit_cnt holds a data-bit index from 0 to DATA_WIDTH-1. It has one spare
    // bit, and it is cleared on every entry to DATA, so it never wraps.
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q,     state_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic                  par_bit_q,   par_bit_d;
    logic                  par_en_q,    par_en_d;
    logic                  two_stop_q,  two_stop_d;
    logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic                  stop_cnt_q,  stop_cnt_d;
    logic                  tx_q,        tx_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    // Parity bit for the word on data_in. It is only used on the accepting
    // edge, where it is captured along with the data. After that, parity_sel
    // and data_in have no effect on the frame in flight.
    logic                  par_calc;

    // Parity from the incoming word: even selects ^data, odd selects ~^data.
    always_comb begin
        par_calc = parity_sel ? ~(^data_in) : (^data_in);
    end

    // State register, shadow registers and registered outputs. Reset returns
    // the line to idle-high and drops busy/done without finishing the frame.
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic. Each branch also sets the line value and flags for the
    // cycle that follows, which keeps the outputs free of glitches and in step
    // with the state.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = 1'b1;
        busy_d     = 1'b1;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
                if (tx_start) begin
                    state_d    = S_START;
                    shift_d    = data_in;
                    par_bit_d  = par_calc;
                    par_en_d   = parity_en;
                    two_stop_d = two_stop;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            S_START: begin
                // Data bit 0 goes on the line as DATA is entered.
                state_d   = S_DATA;
                bit_cnt_d = '0;
                tx_d      = shift_q[0];
                shift_d   = shift_q >> 1;
            end

            S_DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (par_en_q) begin
                        state_d = S_PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d    = S_STOP;
                        stop_cnt_d = 1'b0;
                        tx_d       = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end

            S_PARITY: begin
                state_d    = S_STOP;
                stop_cnt_d = 1'b0;
                tx_d       = 1'b1;
            end

            S_STOP: begin
                if (two_stop_q && (stop_cnt_q == 1'b0)) begin
                    stop_cnt_d = 1'b1;
                    tx_d       = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule
